// File: rtl/sdram_port_sched_if.sv
// Bus bundle between the per-port wb_port buffers, the port scheduler and the
// SDRAM controller. The scheduler takes the slave view; port/controller side is master.
interface sdram_port_sched_if #(
    parameter int unsigned WB_PORTS = 3
);
    logic [WB_PORTS-1:0]    p_acc_i;
    logic [WB_PORTS*32-1:0] p_adr_i;
    logic [WB_PORTS*16-1:0] p_dat_i;
    logic [WB_PORTS*2-1:0]  p_sel_i;
    logic [WB_PORTS-1:0]    p_we_i;
    logic [WB_PORTS-1:0]    p_ack_o;
    logic [31:0]            adr_o;
    logic [15:0]            dat_o;
    logic [1:0]             sel_o;
    logic                   we_o;
    logic                   acc_o;
    logic                   ack_i;

    modport slave (
        input  p_acc_i, p_adr_i, p_dat_i, p_sel_i, p_we_i, ack_i,
        output p_ack_o, adr_o, dat_o, sel_o, we_o, acc_o
    );

    modport master (
        output p_acc_i, p_adr_i, p_dat_i, p_sel_i, p_we_i, ack_i,
        input  p_ack_o, adr_o, dat_o, sel_o, we_o, acc_o
    );
endinterface

// File: rtl/sdram_port_sched.sv
// Time-sliced round-robin owner selection for the SDRAM controller: each port keeps
// the controller for up to QUANTUM acks while others wait, and ownership only moves when idle.
module sdram_port_sched #(
    parameter int unsigned WB_PORTS = 3,
    parameter int unsigned QUANTUM  = 8
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst,
    input  logic                sdram_idle_i,
    output logic [WB_PORTS-1:0] grant_o,
    sdram_port_sched_if.slave   bus
);
    localparam int unsigned IDX_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
    localparam int unsigned CNT_W = $clog2(QUANTUM + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WB_PORTS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWN     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [WB_PORTS-1:0] grant_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    owner_nxt;
    logic [IDX_W-1:0]    last;
    logic [IDX_W-1:0]    last_nxt;

    logic [IDX_W-1:0]    rr_idx;
    logic [IDX_W-1:0]    pick;
    logic                pick_vld;
    logic                other_req;
    logic                force_off;
    logic                acc_c;
    logic [WB_PORTS-1:0] ack_c;
    logic                any_grant;

    // Round-robin search: walk from farthest to nearest so the port right after 'last' wins.
    always_comb begin
        rr_idx   = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = int'(WB_PORTS); k >= 1; k--) begin
            rr_idx = IDX_W'((int'(last) + k) % int'(WB_PORTS));
            if (bus.p_acc_i[rr_idx]) begin
                pick     = rr_idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            cnt     <= '0;
            owner   <= '0;
            last    <= IDX_TOP;
        end else begin
            state   <= state_nxt;
            grant_o <= grant_nxt;
            cnt     <= cnt_nxt;
            owner   <= owner_nxt;
            last    <= last_nxt;
        end
    end

    // Next-state and per-state controller handshake.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        last_nxt  = last;
        acc_c     = 1'b0;
        ack_c     = '0;
        other_req = |(bus.p_acc_i & ~grant_o);
        // Quota used up while someone else waits: stop issuing new accesses.
        force_off = (cnt == CNT_MAX) && other_req;

        case (state)
            ST_IDLE: begin
                if (sdram_idle_i && pick_vld) begin
                    state_nxt = ST_OWN;
                    grant_nxt = WB_PORTS'(1) << pick;
                    cnt_nxt   = '0;
                    owner_nxt = pick;
                end
            end
            ST_OWN: begin
                acc_c        = bus.p_acc_i[owner] & ~force_off;
                ack_c[owner] = bus.ack_i;
                if (bus.ack_i && (cnt != CNT_MAX)) begin
                    cnt_nxt = cnt + 1'b1;
                end
                if (!bus.p_acc_i[owner] ||
                    (bus.ack_i && (cnt == CNT_LAST) && other_req) ||
                    ((cnt == CNT_MAX) && !acc_c && other_req)) begin
                    state_nxt = ST_RELEASE;
                    last_nxt  = owner;
                end
            end
            ST_RELEASE: begin
                if (sdram_idle_i) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Owner's fields stay on the controller bus through RELEASE; zero with no owner.
    assign any_grant   = |grant_o;
    assign bus.adr_o   = any_grant ? bus.p_adr_i[int'(owner)*32 +: 32] : 32'd0;
    assign bus.dat_o   = any_grant ? bus.p_dat_i[int'(owner)*16 +: 16] : 16'd0;
    assign bus.sel_o   = any_grant ? bus.p_sel_i[int'(owner)*2 +: 2] : 2'd0;
    assign bus.we_o    = any_grant & bus.p_we_i[owner];
    assign bus.acc_o   = acc_c;
    assign bus.p_ack_o = ack_c;

endmodule
